// File: rtl/vga_scan_timing_pkg.sv
// Timing constants and shared types for the 800x600@72 VGA raster.
package vga_timing_pkg;

    // Horizontal geometry in pixel clocks.
    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FP     = 56;
    localparam int unsigned H_SYNC   = 120;
    localparam int unsigned H_BP     = 64;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical geometry in lines.
    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned V_FP     = 37;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 23;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows, [START, END).
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Coordinate widths.
    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    // Registered active-video payload handed to the pixel pipeline.
    typedef struct packed {
        logic           hen;
        logic           ven;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           line_start;
        logic           frame_start;
    } scan_t;

endpackage

// File: rtl/vga_scan_timing_if.sv
// Raster timing bus: active-video enables, coordinates, frame markers and syncs.
// master: timing generator drives everything; slave: consumers read everything.
interface vga_scan_timing_if;
    import vga_timing_pkg::*;

    logic           hen;
    logic           ven;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;
    logic           hs;
    logic           vs;

    modport master (output hen, ven, x, y, line_start, frame_start, hs, vs);
    modport slave  (input  hen, ven, x, y, line_start, frame_start, hs, vs);
endinterface

// File: rtl/vga_scan_timing_sync_delay_line.sv
// Fixed-depth shift register that realigns a sync pulse with the RGB pipeline.
// Ports: pclk, rst (async active-high), din -> dout after DEPTH pclk edges.
// Every stage resets to RST_VAL so no stale pulse survives a reset.
module sync_delay_line #(
    parameter int unsigned DEPTH   = 2,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = pclk ^ rst;
            assign dout = din;
        end else if (DEPTH == 1) begin : g_single
            logic q;
            always_ff @(posedge pclk or posedge rst) begin
                if (rst) q <= RST_VAL;
                else     q <= din;
            end
            assign dout = q;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;
            always_ff @(posedge pclk or posedge rst) begin
                if (rst) sr <= {DEPTH{RST_VAL}};
                else     sr <= {sr[DEPTH-2:0], din};
            end
            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_timing.sv
// Free-running raster timing generator: one pixel per pclk.
// Ports: pclk, rst (async active-high), bus (master) carrying hen/ven, x/y,
// line_start/frame_start and the pipeline-aligned hs/vs.
// Geometry defaults to 800x600@72; overrides exist so reduced rasters can be built.
// SYNC_DLY legal range is 0..7.
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned SYNC_DLY   = 2,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned G_H_ACTIVE = H_ACTIVE,
    parameter int unsigned G_H_FP     = H_FP,
    parameter int unsigned G_H_SYNC   = H_SYNC,
    parameter int unsigned G_H_BP     = H_BP,
    parameter int unsigned G_V_ACTIVE = V_ACTIVE,
    parameter int unsigned G_V_FP     = V_FP,
    parameter int unsigned G_V_SYNC   = V_SYNC,
    parameter int unsigned G_V_BP     = V_BP
) (
    input  logic               pclk,
    input  logic               rst,
    vga_scan_timing_if.master  bus
);

    localparam int unsigned HT  = G_H_ACTIVE + G_H_FP + G_H_SYNC + G_H_BP;
    localparam int unsigned VT  = G_V_ACTIVE + G_V_FP + G_V_SYNC + G_V_BP;
    localparam int unsigned HSS = G_H_ACTIVE + G_H_FP;
    localparam int unsigned HSE = HSS + G_H_SYNC;
    localparam int unsigned VSS = G_V_ACTIVE + G_V_FP;
    localparam int unsigned VSE = VSS + G_V_SYNC;

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    scan_t          scan_q;
    logic           hs_q;
    logic           vs_q;
    logic           hs_dly;
    logic           vs_dly;
    logic           h_act_c;
    logic           v_act_c;

    assign h_act_c = (h_cnt < X_W'(G_H_ACTIVE));
    assign v_act_c = (v_cnt < Y_W'(G_V_ACTIVE));

    // Raster counters plus registered decode of the pre-edge counter value.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            scan_q <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
        end else begin
            if (h_cnt == X_W'(HT - 1)) begin
                h_cnt <= '0;
                if (v_cnt == Y_W'(VT - 1)) v_cnt <= '0;
                else                       v_cnt <= v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            scan_q.hen         <= h_act_c;
            scan_q.ven         <= v_act_c;
            scan_q.x           <= h_act_c ? h_cnt : '0;
            scan_q.y           <= v_act_c ? v_cnt : '0;
            scan_q.line_start  <= (h_cnt == '0);
            scan_q.frame_start <= (h_cnt == '0) && (v_cnt == '0);

            hs_q <= (h_cnt >= X_W'(HSS) && h_cnt < X_W'(HSE)) ? HS_POL : ~HS_POL;
            // vs decodes on v only, so it changes on the h = 0 edge of a line.
            vs_q <= (v_cnt >= Y_W'(VSS) && v_cnt < Y_W'(VSE)) ? VS_POL : ~VS_POL;
        end
    end

    sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(~HS_POL)) u_hs_dly (
        .pclk (pclk),
        .rst  (rst),
        .din  (hs_q),
        .dout (hs_dly)
    );

    sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(~VS_POL)) u_vs_dly (
        .pclk (pclk),
        .rst  (rst),
        .din  (vs_q),
        .dout (vs_dly)
    );

    assign bus.hen         = scan_q.hen;
    assign bus.ven         = scan_q.ven;
    assign bus.x           = scan_q.x;
    assign bus.y           = scan_q.y;
    assign bus.line_start  = scan_q.line_start;
    assign bus.frame_start = scan_q.frame_start;
    assign bus.hs          = hs_dly;
    assign bus.vs          = vs_dly;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: full-geometry DUTs with SYNC_DLY 2 and 0, plus a
// reduced-geometry DUT so whole frames and the frame wrap fit in a short run.
module tb_vga_scan_timing;
    import vga_timing_pkg::*;

    // Reduced raster: 25 pixels x 11 lines, vs active-low, 3-cycle sync delay.
    localparam int S_HA = 16, S_HFP = 3, S_HSW = 4, S_HBP = 2;
    localparam int S_VA = 6,  S_VFP = 2, S_VSW = 2, S_VBP = 1;
    localparam int S_D  = 3;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   k    = 0;        // pclk edges since reset release
    int   checks   = 0;
    int   failures = 0;
    bit   run_chk  = 1'b0;

    always #10 pclk = ~pclk;

    always @(posedge pclk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    vga_scan_timing_if if_a ();
    vga_scan_timing_if if_z ();
    vga_scan_timing_if if_s ();

    vga_scan_timing #(.SYNC_DLY(2)) dut_a (.pclk(pclk), .rst(rst), .bus(if_a));
    vga_scan_timing #(.SYNC_DLY(0)) dut_z (.pclk(pclk), .rst(rst), .bus(if_z));
    vga_scan_timing #(
        .SYNC_DLY(S_D), .HS_POL(1'b1), .VS_POL(1'b0),
        .G_H_ACTIVE(S_HA), .G_H_FP(S_HFP), .G_H_SYNC(S_HSW), .G_H_BP(S_HBP),
        .G_V_ACTIVE(S_VA), .G_V_FP(S_VFP), .G_V_SYNC(S_VSW), .G_V_BP(S_VBP)
    ) dut_s (.pclk(pclk), .rst(rst), .bus(if_s));

    // Expected outputs after the k-th edge following release, from the raster rules:
    // edge k shows pixel t = k-1; syncs show pixel t-d (inactive before time 0).
    // Packing: {hen, ven, x[10:0], y[9:0], line_start, frame_start, hs, vs}.
    function automatic logic [26:0] model(input int kk, input bit r,
                                          input int ha, input int hfp, input int hsw, input int hbp,
                                          input int va, input int vfp, input int vsw, input int vbp,
                                          input int d, input bit hp, input bit vp);
        int  ht, vt, t, h, v, td, h2, v2;
        bit  he, ve, ls, fs, hs, vs;
        logic [10:0] xv;
        logic [9:0]  yv;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (r || kk == 0) return {1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, ~hp, ~vp};
        t  = kk - 1;
        h  = t % ht;
        v  = (t / ht) % vt;
        he = (h < ha);
        ve = (v < va);
        xv = he ? 11'(h) : 11'd0;
        yv = ve ? 10'(v) : 10'd0;
        ls = (h == 0);
        fs = (h == 0) && (v == 0);
        td = t - d;
        hs = ~hp;
        vs = ~vp;
        if (td >= 0) begin
            h2 = td % ht;
            v2 = (td / ht) % vt;
            if (h2 >= ha + hfp && h2 < ha + hfp + hsw) hs = hp;
            if (v2 >= va + vfp && v2 < va + vfp + vsw) vs = vp;
        end
        return {he, ve, xv, yv, ls, fs, hs, vs};
    endfunction

    task automatic chk_vec(input string nm, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0d want=%0d", nm, k, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of every DUT against the model.
    always @(negedge pclk) begin
        if (run_chk) begin
            chk_vec("model_a",
                {if_a.hen, if_a.ven, if_a.x, if_a.y, if_a.line_start, if_a.frame_start, if_a.hs, if_a.vs},
                model(k, rst, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, 2, 1'b1, 1'b1));
            chk_vec("model_z",
                {if_z.hen, if_z.ven, if_z.x, if_z.y, if_z.line_start, if_z.frame_start, if_z.hs, if_z.vs},
                model(k, rst, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, 0, 1'b1, 1'b1));
            chk_vec("model_s",
                {if_s.hen, if_s.ven, if_s.x, if_s.y, if_s.line_start, if_s.frame_start, if_s.hs, if_s.vs},
                model(k, rst, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, S_D, 1'b1, 1'b0));
        end
    end

    int hen_cnt_a = 0, hs_cnt_a = 0, ls_cnt_a = 0, xmax_a = 0;
    int fs_cnt_s = 0, ven_cnt_s = 0, ymax_s = 0;
    int z_hen_fall = -1, z_hs_rise = -1;
    int stale_hs = 0;

    initial begin
        // Reset held for 5 cycles.
        @(negedge pclk);
        run_chk = 1'b1;
        chk("rst_hs_a",  int'(if_a.hs),  0);
        chk("rst_vs_a",  int'(if_a.vs),  0);
        chk("rst_hen_a", int'(if_a.hen), 0);
        repeat (4) @(negedge pclk);
        rst = 1'b0;

        // Three full-width lines; many reduced frames.
        for (int i = 0; i < 2980; i++) begin
            @(negedge pclk);
            if (k <= 1040) begin
                hen_cnt_a += int'(if_a.hen);
                hs_cnt_a  += int'(if_a.hs);
            end
            ls_cnt_a += int'(if_a.line_start);
            if (int'(if_a.x) > xmax_a) xmax_a = int'(if_a.x);
            if (k <= 825) fs_cnt_s += int'(if_s.frame_start);
            if (k <= 275) ven_cnt_s += int'(if_s.ven);
            if (int'(if_s.y) > ymax_s) ymax_s = int'(if_s.y);
            if (k <= 1040 && z_hen_fall < 0 && !if_z.hen) z_hen_fall = k;
            if (k <= 1040 && z_hs_rise < 0 && if_z.hs)   z_hs_rise  = k;
            case (k)
                1: begin
                    chk("first_hen", int'(if_a.hen), 1);
                    chk("first_ven", int'(if_a.ven), 1);
                    chk("first_x",   int'(if_a.x),   0);
                    chk("first_y",   int'(if_a.y),   0);
                    chk("first_fs",  int'(if_a.frame_start), 1);
                end
                800:  chk("last_x",       int'(if_a.x),   799);
                801:  chk("hen_fall",     int'(if_a.hen), 0);
                858:  chk("hs_pre_rise",  int'(if_a.hs),  0);
                859:  chk("hs_rise",      int'(if_a.hs),  1);
                978:  chk("hs_last",      int'(if_a.hs),  1);
                979:  chk("hs_fall",      int'(if_a.hs),  0);
                1041: begin
                    chk("line1_ls", int'(if_a.line_start), 1);
                    chk("line1_y",  int'(if_a.y),          1);
                end
                default: ;
            endcase
            case (k)
                126: chk_vec("s_row5", {if_s.x, if_s.y, if_s.line_start, if_s.hen},
                             {11'd0, 10'd5, 1'b1, 1'b1});
                203: chk("s_vs_idle", int'(if_s.vs), 1);
                204: chk("s_vs_act",  int'(if_s.vs), 0);
                275: chk_vec("s_wrap_pre", {if_s.hen, if_s.ven, if_s.frame_start},
                             {1'b0, 1'b0, 1'b0});
                276: chk_vec("s_wrap", {if_s.hen, if_s.ven, if_s.x, if_s.y, if_s.frame_start},
                             {1'b1, 1'b1, 11'd0, 10'd0, 1'b1});
                default: ;
            endcase
        end

        chk("hen_cnt_line",   hen_cnt_a, 800);
        chk("hs_cnt_line",    hs_cnt_a,  120);
        chk("ls_cnt_3lines",  ls_cnt_a,  3);
        chk("x_max",          xmax_a,    799);
        chk("s_fs_3frames",   fs_cnt_s,  3);
        chk("s_ven_frame",    ven_cnt_s, 150);
        chk("s_y_max",        ymax_s,    5);
        chk("z_hs_after_hen", z_hs_rise - z_hen_fall, 56);

        // Async reset in the middle of an hs pulse (line 2, pixel 899).
        chk("pre_rst_hs", int'(if_a.hs), 1);
        @(posedge pclk);
        #1 rst = 1'b1;
        #1;
        chk_vec("async_rst_a",
            {if_a.hen, if_a.ven, if_a.x, if_a.y, if_a.line_start, if_a.frame_start, if_a.hs, if_a.vs},
            {1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("async_rst_vs_s", int'(if_s.vs), 1);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;

        for (int i = 0; i < 1100; i++) begin
            @(negedge pclk);
            if (k < 859) stale_hs += int'(if_a.hs);
            if (k == 1) chk("restart_fs", int'(if_a.frame_start), 1);
            if (k == 859) chk("restart_hs_rise", int'(if_a.hs), 1);
        end
        chk("no_stale_hs", stale_hs, 0);

        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
